cascade_counter: RTL and testbench

CASCADE_COUNTER -- requirements
Module: cascade_counter

---
 rtl/cascade_counter.sv | 129 ++++++++++++
 tb/tb_cascade_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// Purpose : cascaded modulo-N digit counter (BCD at default) with load, clear and sticky wrap flag.
// Latency : one clk edge from enable/load/clear to q_out; rco is combinational from state, ent and up.
// Backpress: none; enp/ent low simply holds the count, ent also gates rco for chaining further instances.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high reset (q_out, ovf, lderr -> 0)
//   sclrn    synchronous clear, active-low (highest synchronous priority)
//   ldn      synchronous parallel load, active-low
//   enp, ent count enables; both high to count, ent alone gates rco
//   up       1 = count up, 0 = count down
//   data_in  load value, DIGITS digits of DW bits, digit 0 in the LSBs
//   q_out    registered count, same packing as data_in
//   rco      ripple carry/borrow out: ent and every digit at its terminal value
//   ovf      sticky flag, set when the whole counter wraps
//   lderr    set when the last load held a digit >= MODULUS
module cascade_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 10,
    localparam int DW     = $clog2(MODULUS)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 sclrn,
    input  logic                 ldn,
    input  logic                 enp,
    input  logic                 ent,
    input  logic                 up,
    input  logic [DIGITS*DW-1:0] data_in,
    output logic [DIGITS*DW-1:0] q_out,
    output logic                 rco,
    output logic                 ovf,
    output logic                 lderr
);

    // Largest digit value; always fits in DW bits.
    localparam logic [DW-1:0] MAX_DIG = DW'(MODULUS - 1);
    // MODULUS itself may equal 2**DW, so range checks use one extra bit.
    localparam logic [DW:0]   MOD_W   = (DW + 1)'(MODULUS);

    logic [DIGITS-1:0][DW-1:0] cnt_q;
    logic [DIGITS-1:0][DW-1:0] cnt_d;
    logic [DIGITS-1:0][DW-1:0] load_val;
    logic [DIGITS-1:0]         term;
    logic [DIGITS-1:0]         bad_dig;
    // carry[k] is high when every digit below k sits at its terminal value,
    // i.e. digit k steps on a count edge. carry[DIGITS] means full wrap.
    logic [DIGITS:0]           carry;
    logic                      all_term;
    logic                      count_en;
    logic                      ovf_q;
    logic                      ovf_d;
    logic                      lderr_q;
    logic                      lderr_d;

    // One step of a single digit in the requested direction, wrapping at the ends.
    function automatic logic [DW-1:0] dig_step(input logic [DW-1:0] d, input logic dir_up);
        logic [DW-1:0] r;
        if (dir_up) begin
            r = (d == MAX_DIG) ? '0 : d + DW'(1);
        end else begin
            r = (d == '0) ? MAX_DIG : d - DW'(1);
        end
        return r;
    endfunction

    // Terminal detection, carry chain and load sanitising.
    always_comb begin
        term     = '0;
        bad_dig  = '0;
        load_val = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            term[k]      = up ? (cnt_q[k] == MAX_DIG) : (cnt_q[k] == '0);
            carry[k + 1] = carry[k] & term[k];
            bad_dig[k]   = {1'b0, data_in[k*DW +: DW]} >= MOD_W;
            load_val[k]  = bad_dig[k] ? '0 : data_in[k*DW +: DW];
        end
    end

    assign all_term = carry[DIGITS];
    assign count_en = enp & ent;

    // While clr is held the digits are all zero, so this naturally reduces to ent & ~up.
    assign rco = ent & all_term;

    // Next-state: clear beats load beats count, otherwise hold.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        lderr_d = lderr_q;
        if (!sclrn) begin
            cnt_d   = '0;
            ovf_d   = 1'b0;
            lderr_d = 1'b0;
        end else if (!ldn) begin
            cnt_d   = load_val;
            ovf_d   = 1'b0;
            lderr_d = |bad_dig;
        end else if (count_en) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (carry[k]) begin
                    cnt_d[k] = dig_step(cnt_q[k], up);
                end
            end
            if (all_term) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lderr_q <= lderr_d;
        end
    end

    assign q_out = cnt_q;
    assign ovf   = ovf_q;
    assign lderr = lderr_q;

endmodule

// File: tb/tb_cascade_counter.sv
module tb_cascade_counter;

    logic       clk;
    logic       clr;
    logic       sclrn;
    logic       ldn;
    logic       enp;
    logic       ent;
    logic       up;
    logic [7:0] data_in;
    logic [7:0] q_out;
    logic       rco;
    logic       ovf;
    logic       lderr;

    // Second instance: 3 digits, base 6 (3 bits per digit).
    logic [8:0] data_in2;
    logic [8:0] q_out2;
    logic       rco2;
    logic       ovf2;
    logic       lderr2;

    int n_chk;
    int n_fail;

    cascade_counter #(.DIGITS(2), .MODULUS(10)) dut (
        .clk(clk), .clr(clr), .sclrn(sclrn), .ldn(ldn), .enp(enp), .ent(ent), .up(up),
        .data_in(data_in), .q_out(q_out), .rco(rco), .ovf(ovf), .lderr(lderr)
    );

    cascade_counter #(.DIGITS(3), .MODULUS(6)) dut2 (
        .clk(clk), .clr(clr), .sclrn(sclrn), .ldn(ldn), .enp(enp), .ent(ent), .up(up),
        .data_in(data_in2), .q_out(q_out2), .rco(rco2), .ovf(ovf2), .lderr(lderr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sclrn;
        logic       ldn;
        logic       enp;
        logic       ent;
        logic       up;
        logic [7:0] din;
        logic [7:0] q;
        logic       rco;
        logic       ovf;
        logic       lderr;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [8:0] b6(input int v);
        logic [2:0] d2;
        logic [2:0] d1;
        logic [2:0] d0;
        d0 = 3'(v % 6);
        d1 = 3'((v / 6) % 6);
        d2 = 3'(v / 36);
        return {d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic s, input logic l, input logic p, input logic t,
                                input logic u, input logic [7:0] din, input logic [7:0] q,
                                input logic r, input logic o, input logic e);
        vec_t v;
        v.sclrn = s; v.ldn = l; v.enp = p; v.ent = t; v.up = u; v.din = din;
        v.q = q; v.rco = r; v.ovf = o; v.lderr = e;
        return v;
    endfunction

    logic [7:0] exp_q;

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //         sclrn ldn enp ent up  din     q      rco ovf lderr
        vecs[0]  = mk(1, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0, 0); // first edge after clr: load
        vecs[1]  = mk(0, 0, 1, 1, 1, 8'h45, 8'h00, 0, 0, 0); // clear beats load and count
        vecs[2]  = mk(1, 0, 1, 1, 1, 8'h37, 8'h37, 0, 0, 0); // load beats count
        vecs[3]  = mk(1, 1, 1, 1, 1, 8'h00, 8'h38, 0, 0, 0);
        vecs[4]  = mk(1, 1, 1, 1, 1, 8'h00, 8'h39, 0, 0, 0);
        vecs[5]  = mk(1, 1, 1, 1, 1, 8'h00, 8'h40, 0, 0, 0); // carry into tens
        vecs[6]  = mk(1, 0, 0, 0, 1, 8'hA3, 8'h03, 0, 0, 1); // bad tens digit -> 0
        vecs[7]  = mk(1, 1, 0, 1, 1, 8'h00, 8'h03, 0, 0, 1); // enp=0 holds
        vecs[8]  = mk(1, 0, 0, 0, 1, 8'h12, 8'h12, 0, 0, 0); // valid load clears lderr
        vecs[9]  = mk(1, 0, 0, 0, 1, 8'hF9, 8'h09, 0, 0, 1);
        vecs[10] = mk(0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0); // sclrn clears lderr
        vecs[11] = mk(1, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0);
        vecs[12] = mk(1, 1, 1, 1, 0, 8'h00, 8'h09, 0, 0, 0); // borrow
        vecs[13] = mk(1, 1, 1, 1, 0, 8'h00, 8'h08, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0); // 00 is terminal down
        vecs[15] = mk(1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1, 0); // down wrap sets ovf
        vecs[16] = mk(1, 1, 0, 1, 1, 8'h00, 8'h99, 1, 1, 0); // rco independent of enp
        vecs[17] = mk(1, 1, 0, 0, 1, 8'h00, 8'h99, 0, 1, 0); // ent=0 gates rco
        vecs[18] = mk(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 0); // up wrap, ovf sticky
        vecs[19] = mk(1, 1, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0);
        vecs[20] = mk(1, 1, 1, 1, 0, 8'h00, 8'h99, 0, 1, 0); // direction change, no lag
        vecs[21] = mk(1, 0, 1, 1, 1, 8'h26, 8'h26, 0, 0, 0); // load clears ovf
        vecs[22] = mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);

        // Reset state, asserted from time 0.
        clr = 1'b1; sclrn = 1'b1; ldn = 1'b1; enp = 1'b0; ent = 1'b1; up = 1'b0;
        data_in = 8'h00; data_in2 = 9'h000;
        #3;
        chk("reset_q", 32'(q_out), 32'h00);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_lderr", 32'(lderr), 32'h0);
        chk("reset_rco_down", 32'(rco), 32'h1);
        up = 1'b1;
        #1;
        chk("reset_rco_up", 32'(rco), 32'h0);

        // clr overrides a load and counting across an edge.
        ldn = 1'b0; data_in = 8'h55; enp = 1'b1;
        @(posedge clk); #1;
        chk("clr_over_load", 32'(q_out), 32'h00);
        clr = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 23; i++) begin
            sclrn = vecs[i].sclrn; ldn = vecs[i].ldn; enp = vecs[i].enp;
            ent = vecs[i].ent; up = vecs[i].up; data_in = vecs[i].din;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_q", i), 32'(q_out), 32'(vecs[i].q));
            chk($sformatf("vec%0d_rco", i), 32'(rco), 32'(vecs[i].rco));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_lderr", i), 32'(lderr), 32'(vecs[i].lderr));
        end

        // Full up-count: 100 edges through 00..99 and back to 00.
        clr = 1'b1; #2; clr = 1'b0;
        sclrn = 1'b1; ldn = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1; data_in = 8'h00;
        exp_q = 8'h00;
        for (int i = 1; i <= 100; i++) begin
            chk($sformatf("up_rco_%0d", i), 32'(rco), 32'(exp_q == 8'h99));
            if (exp_q == 8'h99) begin
                up = 1'b0; #1;
                chk("rco_follows_up", 32'(rco), 32'h0);
                up = 1'b1; #1;
                chk("rco_follows_up_back", 32'(rco), 32'h1);
            end
            @(posedge clk); #1;
            exp_q = bcd(i % 100);
            chk($sformatf("up_q_%0d", i), 32'(q_out), 32'(exp_q));
            chk($sformatf("up_ovf_%0d", i), 32'(ovf), 32'(i == 100));
        end

        // Continue to 58 with ovf still set, then async clear mid-cycle.
        for (int i = 1; i <= 58; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_clr_q", 32'(q_out), 32'h58);
        chk("pre_clr_ovf", 32'(ovf), 32'h1);
        #2; clr = 1'b1; #1;
        chk("async_clr_q", 32'(q_out), 32'h00);
        chk("async_clr_ovf", 32'(ovf), 32'h0);
        @(posedge clk); #1;
        chk("clr_held_q", 32'(q_out), 32'h00);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("after_clr_first_step", 32'(q_out), 32'h01);

        // 3-digit base-6 instance: full wrap after 216 steps.
        clr = 1'b1; #2; clr = 1'b0;
        chk("b6_reset", 32'(q_out2), 32'h000);
        for (int i = 1; i <= 216; i++) begin
            chk($sformatf("b6_rco_%0d", i), 32'(rco2), 32'(i == 216));
            @(posedge clk); #1;
            chk($sformatf("b6_q_%0d", i), 32'(q_out2), 32'(b6(i % 216)));
            chk($sformatf("b6_ovf_%0d", i), 32'(ovf2), 32'(i == 216));
        end
        chk("b6_lderr", 32'(lderr2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
